// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives the 8 input combinations of a 3-input gate in order 000..111.
// Each vector is held for SETTLE cycles and then sampled for one cycle. The
// sampled gate output is compared with EXPECT[index], and mismatches are counted.
//
// Parameters:
//   SETTLE  drive cycles per vector before sampling (1..15)
//   EXPECT  expected gate output; bit i applies to vector i (default 3-input AND)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a sweep (only looked at in IDLE)
//   dut_out    output of the gate under test
//   in0..in2   registered stimulus, {in2,in1,in0} = vector index
//   busy       high while vectors are being driven/sampled
//   done       high from sweep completion until the next accepted start
//   pass       valid with done; 1 when err_count is 0
//   err_count  mismatching vectors in the last sweep (0..8)
// Optional build macro:
//   SWEEPER_STOP_ON_FAIL_EN  the first mismatch ends the sweep immediately
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1,
  parameter logic [7:0]  EXPECT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Last value of the wait counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_r, state_s;
  logic [2:0] index_r, index_s;
  logic [3:0] wait_r, wait_s;
  logic [3:0] err_s;
  logic       done_s, pass_s, busy_s;
  logic [2:0] stim_s;
  logic       mismatch_s;

  // Next-state, counter and next-output computation.
  always_comb begin
    state_s    = state_r;
    index_s    = index_r;
    wait_s     = wait_r;
    err_s      = err_count;
    done_s     = done;
    pass_s     = pass;
    mismatch_s = (dut_out != EXPECT[index_r]);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SETTLE;
          index_s = 3'd0;
          wait_s  = 4'd0;
          err_s   = 4'd0;
          done_s  = 1'b0;
          pass_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (wait_r == SETTLE_LAST) begin
          state_s = ST_SAMPLE;
          wait_s  = 4'd0;
        end else begin
          wait_s  = wait_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        // At most 8 increments per sweep, so 4 bits cannot overflow.
        if (mismatch_s) begin
          err_s = err_count + 4'd1;
        end else begin
          err_s = err_count;
        end
`ifdef SWEEPER_STOP_ON_FAIL_EN
        if (mismatch_s || (index_r == 3'd7)) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_SETTLE;
          index_s = index_r + 3'd1;
        end
`else
        if (index_r == 3'd7) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_SETTLE;
          index_s = index_r + 3'd1;
        end
`endif
      end
      ST_FINISH: begin
        // err_count already includes the final vector's sample here.
        state_s = ST_IDLE;
        index_s = 3'd0;
        done_s  = 1'b1;
        pass_s  = (err_count == 4'd0);
      end
      default: begin
        state_s = ST_IDLE;
        index_s = 3'd0;
        wait_s  = 4'd0;
      end
    endcase
    // Outputs are registered from the next state so that they line up with it.
    busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
    if (busy_s) begin
      stim_s = index_s;
    end else begin
      stim_s = 3'd0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      index_r         <= 3'd0;
      wait_r          <= 4'd0;
      err_count       <= 4'd0;
      done            <= 1'b0;
      pass            <= 1'b0;
      busy            <= 1'b0;
      {in2, in1, in0} <= 3'd0;
    end else begin
      state_r         <= state_s;
      index_r         <= index_s;
      wait_r          <= wait_s;
      err_count       <= err_s;
      done            <= done_s;
      pass            <= pass_s;
      busy            <= busy_s;
      {in2, in1, in0} <= stim_s;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// Two instances are used: SETTLE=1 and SETTLE=3, both with the default AND
// expectation. Each gate under test is modelled as an 8-entry response table
// that is indexed by the stimulus.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [7:0] resp_v [2];

  logic [2:0] stim_v [2];
  logic [1:0] busy_v, done_v, pass_v, dout_v;
  logic [3:0] err_v [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dout_v[0] = resp_v[0][stim_v[0]];
  assign dout_v[1] = resp_v[1][stim_v[1]];

  truth_table_sweeper #(.SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_out(dout_v[0]),
    .in0(stim_v[0][0]), .in1(stim_v[0][1]), .in2(stim_v[0][2]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0])
  );

  truth_table_sweeper #(.SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_out(dout_v[1]),
    .in0(stim_v[1][0]), .in1(stim_v[1][1]), .in2(stim_v[1][2]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  // Reference: compare the gate's truth table against the AND table.
  function automatic void model(input int s, input logic [7:0] resp,
                                output int errs, output int nbusy);
    logic [7:0] mism;
    int first;
    mism  = resp ^ 8'h80;
    errs  = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (mism[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    nbusy = 8 * (s + 1);
`ifdef SWEEPER_STOP_ON_FAIL_EN
    if (first >= 0) begin
      errs  = 1;
      nbusy = (first + 1) * (s + 1);
    end
`endif
  endfunction

  // Pulse start, then follow the sweep until busy drops, and end in IDLE.
  task automatic run_sweep(input int sel, input logic [7:0] resp,
                           output int nbusy, output int order_bad, output int done_bad);
    int s;
    s = settle_of(sel);
    @(negedge clk);
    resp_v[sel]  = resp;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    nbusy = 0; order_bad = 0; done_bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (!busy_v[sel]) break;
      if (int'(stim_v[sel]) != nbusy / (s + 1)) order_bad++;
      if (done_v[sel]) done_bad++;
      nbusy++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] resp;
    int         exp_err;
    int         exp_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int nb, ob, db, n1, gap, n2, found;
    logic gap_done;
    resp_v[0] = 8'h80;
    resp_v[1] = 8'h80;

    // Directed entries (AND gate, tied 0, tied 1).
`ifdef SWEEPER_STOP_ON_FAIL_EN
    tbl[0] = '{0, 8'h80, 0, 16};
    tbl[1] = '{0, 8'h00, 1, 16};
    tbl[2] = '{1, 8'hFF, 1, 4};
    tbl[3] = '{0, 8'hFF, 1, 2};
    tbl[4] = '{1, 8'h80, 0, 32};
    tbl[5] = '{1, 8'h00, 1, 32};
`else
    tbl[0] = '{0, 8'h80, 0, 16};
    tbl[1] = '{0, 8'h00, 1, 16};
    tbl[2] = '{1, 8'hFF, 7, 32};
    tbl[3] = '{0, 8'hFF, 7, 16};
    tbl[4] = '{1, 8'h80, 0, 32};
    tbl[5] = '{1, 8'h00, 1, 32};
`endif
    for (int i = 6; i < 14; i++) begin
      tbl[i].sel  = int'($urandom_range(1, 0));
      tbl[i].resp = 8'($urandom);
      model(settle_of(tbl[i].sel), tbl[i].resp, tbl[i].exp_err, tbl[i].exp_busy);
    end

    // Reset state, and start accepted on the first edge after release.
    repeat (3) @(negedge clk);
    chk("reset_outputs0", int'({stim_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0]}), 0);
    chk("reset_outputs1", int'({stim_v[1], busy_v[1], done_v[1], pass_v[1], err_v[1]}), 0);
    rst = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("start_after_reset_busy", int'(busy_v[0]), 1);
    for (int c = 0; c < 100; c++) begin
      if (!busy_v[0]) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Table-driven sweeps.
    foreach (tbl[i]) begin
      run_sweep(tbl[i].sel, tbl[i].resp, nb, ob, db);
      chk($sformatf("busy_cycles[%0d]", i), nb, tbl[i].exp_busy);
      chk($sformatf("vector_order_bad[%0d]", i), ob, 0);
      chk($sformatf("done_during_sweep[%0d]", i), db, 0);
      chk($sformatf("done[%0d]", i), int'(done_v[tbl[i].sel]), 1);
      chk($sformatf("err_count[%0d]", i), int'(err_v[tbl[i].sel]), tbl[i].exp_err);
      chk($sformatf("pass[%0d]", i), int'(pass_v[tbl[i].sel]), (tbl[i].exp_err == 0) ? 1 : 0);
      repeat (2) @(negedge clk);
      chk($sformatf("done_held[%0d]", i), int'(done_v[tbl[i].sel]), 1);
    end

    // Reset in the middle of a sweep at vector 4.
    @(negedge clk);
    resp_v[0]  = 8'h80;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (stim_v[0] == 3'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_index4", found, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({stim_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", int'({busy_v[0], done_v[0]}), 0);
    run_sweep(0, 8'h80, nb, ob, db);
    chk("post_abort_busy", nb, 16);
    chk("post_abort_pass", int'({done_v[0], pass_v[0]}), 3);

    // start held high: back-to-back sweeps, mid-sweep start has no effect.
    @(negedge clk);
    resp_v[0]  = 8'h80;
    start_v[0] = 1'b1;
    @(negedge clk);
    n1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_v[0]) break;
      n1++;
      @(negedge clk);
    end
    gap = 0;
    gap_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy_v[0]) break;
      gap++;
      gap_done = done_v[0];
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    n2 = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_v[0]) break;
      n2++;
      @(negedge clk);
    end
    chk("held_start_first_busy", n1, 16);
    chk("held_start_gap", gap, 2);
    chk("held_start_done_in_idle", int'(gap_done), 1);
    chk("held_start_second_busy", n2, 16);
    repeat (3) @(negedge clk);
    chk("held_start_final", int'({done_v[0], pass_v[0], err_v[0]}), 6'b110000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
